// File: rtl/sel_table_pkg.sv
// Shared types and helpers for the sel_table select-and-lookup block.
// Mode encoding and reset-content function used by the top and the bench.
package sel_table_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } mode_t;

  // Reset contents: entry i holds i, truncated to width bits (callers
  // size-cast the 32-bit result, which zero-extends for wide entries).
  function automatic logic [31:0] rst_entry(input int i, input int width);
    logic [31:0] mask;
    if (width >= 32) mask = '1;
    else             mask = (32'd1 << width) - 32'd1;
    return 32'(i) & mask;
  endfunction

endpackage

// File: rtl/sel_table_scan_ctr.sv
// Modulo-DEPTH scan pointer with enable; 'last' marks index DEPTH-1.
// DEPTH need not be a power of two, so the wrap is an explicit compare.
import sel_table_pkg::*;

module sel_table_scan_ctr #(
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [SEL_W-1:0] idx,
  output logic             last
);

  logic [SEL_W-1:0] idx_d;

  always_comb begin
    last  = (int'(idx) == DEPTH - 1);
    idx_d = idx;
    if (en) begin
      if (last) idx_d = '0;
      else      idx_d = idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else       idx <= idx_d;
  end

endmodule

// File: rtl/sel_table.sv
// Registered select-and-lookup table with write port and auto-scan mode.
// Optional macro SEL_TABLE_BYPASS_EN: same-cycle write/read of one index is write-first.
import sel_table_pkg::*;

module sel_table #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             rd_en,
  input  logic             auto,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             data_vld,
  output logic [SEL_W-1:0] scan_idx,
  output logic             scan_wrap,
  output mode_t            dbg_state
);

  // Handshake: data_vld is a one-cycle "fresh data" strobe with no
  // backpressure; consumers must take data in the cycle data_vld is high.

  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             scan_en;
  logic             scan_last;
  logic             rd_fire;
  logic [SEL_W-1:0] rd_idx;
  logic             rd_in_range;
  logic             wr_in_range;
  logic [WIDTH-1:0] rd_val;

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MANUAL;
    else       mode_q <= mode_d;
  end

  // The mode is decided from auto directly, so the first cycle auto is
  // seen high already performs a scan read.
  always_comb begin
    mode_d      = auto ? SCAN : MANUAL;
    scan_en     = (mode_d == SCAN);
    rd_fire     = scan_en | rd_en;
    rd_idx      = scan_en ? scan_idx : sel;
    rd_in_range = (int'(rd_idx) < DEPTH);
    wr_in_range = (int'(wr_addr) < DEPTH);
    rd_val      = rd_in_range ? mem[rd_idx] : '0;
`ifdef SEL_TABLE_BYPASS_EN
    if (wr_en && wr_in_range && (wr_addr == rd_idx)) rd_val = wr_data;
`endif
  end

  assign dbg_state = mode_q;

  sel_table_scan_ctr #(
    .DEPTH (DEPTH)
  ) u_scan_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (scan_en),
    .idx   (scan_idx),
    .last  (scan_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(rst_entry(i, WIDTH));
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // scan_wrap is registered with the read so it lines up with entry DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= '0;
      data_vld  <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      data_vld  <= rd_fire;
      scan_wrap <= scan_en & scan_last;
      if (rd_fire) data <= rd_val;
    end
  end

endmodule
